// File: rtl/saber_ctrl_pkg.sv
// saber_ctrl_pkg: Saber core command encoding, opcodes, sequencer states and the decapsulation program ROM.
package saber_ctrl_pkg;

    localparam int OP_W  = 5;
    localparam int ARG_W = 10;
    localparam int CMD_W = 3 * ARG_W + OP_W;

    localparam logic [OP_W-1:0] OP_BS2POLVECP = 5'd9;
    localparam logic [OP_W-1:0] OP_VMUL       = 5'd10;
    localparam logic [OP_W-1:0] OP_UNPACK     = 5'd11;
    localparam logic [OP_W-1:0] OP_COPY       = 5'd12;

    typedef struct packed {
        logic [ARG_W-1:0] arg2;
        logic [ARG_W-1:0] arg1;
        logic [ARG_W-1:0] arg0;
        logic [OP_W-1:0]  op;
    } cmd_word_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_DONE, S_HOLD, S_CLEAR, S_WAIT_LOW, S_GAP, S_FINISH
    } seq_state_t;

    localparam int DEC_PROG_LEN = 4;

    localparam cmd_word_t DEC_PROG [DEC_PROG_LEN] = '{
        '{10'd512, 10'd0,   10'd0,   OP_BS2POLVECP},
        '{10'd0,   10'd0,   10'd512, OP_VMUL},
        '{10'd512, 10'd120, 10'd0,   OP_UNPACK},
        '{10'd516, 10'd4,   10'd136, OP_COPY}
    };

    // Out-of-range indices read as the zero word instead of wrapping.
    function automatic cmd_word_t dec_prog_word(input logic [2:0] idx);
        return (idx < 3'(DEC_PROG_LEN)) ? DEC_PROG[idx[1:0]] : '0;
    endfunction

endpackage

// File: rtl/done_select.sv
// done_select: picks the core completion flag that belongs to an opcode; unknown opcodes select a constant 0.
module done_select
    import saber_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic            done_shake,
    input  logic            done_vmul,
    input  logic            done_addround,
    input  logic            done_addpack,
    input  logic            done_bs2polvecp,
    input  logic            done_unpack,
    output logic            done_sel
);

    logic unused_done;

    assign unused_done = done_shake ^ done_addround ^ done_addpack;

    always_comb begin
        done_sel = (op == OP_BS2POLVECP)                 ? done_bs2polvecp :
                   (op == OP_VMUL)                       ? done_vmul       :
                   (op == OP_UNPACK || op == OP_COPY)    ? done_unpack     : 1'b0;
    end

endmodule

// File: rtl/kem_dec_sequencer.sv
// kem_dec_sequencer: walks the Saber decapsulation command program through the core's
// issue/done/clear handshake with a per-wait watchdog, gating host RAM writes while busy.
module kem_dec_sequencer
    import saber_ctrl_pkg::*;
#(
    parameter int NUM_STEPS      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       err_step,
    output logic [CMD_W-1:0] command_out,
    output logic             command_we0,
    output logic             command_we1,
    input  logic             done_shake,
    input  logic             done_vmul,
    input  logic             done_addround,
    input  logic             done_addpack,
    input  logic             done_bs2polvecp,
    input  logic             done_unpack,
    input  logic             host_wea,
    output logic             wea_ext,
    output logic             host_blocked
);

    localparam int              WD_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      LAST_STEP = 3'(NUM_STEPS - 1);

    seq_state_t      state_q, state_d;
    logic [2:0]      step_q, step_d;
    logic [WD_W-1:0] wd_q, wd_d;
    cmd_word_t       cmd_q, cmd_d, nxt_cmd;
    logic [OP_W-1:0] op_q, op_d;
    logic            we0_q, we0_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [2:0]      err_step_q, err_step_d;
    logic            blocked_q, blocked_d;
    logic            sel_done;
    logic            timeout;

    done_select u_done_select (
        .op              (op_q),
        .done_shake      (done_shake),
        .done_vmul       (done_vmul),
        .done_addround   (done_addround),
        .done_addpack    (done_addpack),
        .done_bs2polvecp (done_bs2polvecp),
        .done_unpack     (done_unpack),
        .done_sel        (sel_done)
    );

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        error_d    = error_q;
        err_step_d = err_step_q;
        timeout    = 1'b0;
        case (state_q)
            S_IDLE:      if (start && !abort) begin
                             state_d = S_ISSUE;
                             step_d  = '0;
                             error_d = 1'b0;
                         end
            S_ISSUE:     state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (sel_done) state_d = S_HOLD; else timeout = (wd_q == WD_LAST);
            S_HOLD:      state_d = S_CLEAR;
            S_CLEAR:     state_d = S_WAIT_LOW;
            S_WAIT_LOW:  if (!sel_done) state_d = S_GAP; else timeout = (wd_q == WD_LAST);
            S_GAP:       if (step_q == LAST_STEP) state_d = S_FINISH;
                         else begin
                             state_d = S_ISSUE;
                             step_d  = step_q + 3'd1;
                         end
            default:     state_d = S_IDLE;
        endcase
        if (timeout) begin
            state_d    = S_IDLE;
            error_d    = 1'b1;
            err_step_d = step_q;
        end
        // Abort wins over everything, including a timeout in the same cycle.
        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            error_d    = error_q;
            err_step_d = err_step_q;
        end
        wd_d      = (state_d != state_q) ? '0 :
                    (state_q == S_WAIT_DONE || state_q == S_WAIT_LOW) ? wd_q + 1'b1 : wd_q;
        nxt_cmd   = dec_prog_word(step_d);
        cmd_d     = (state_d == S_ISSUE) ? nxt_cmd :
                    (state_d == S_WAIT_DONE || state_d == S_HOLD) ? cmd_q : '0;
        op_d      = (state_d == S_ISSUE) ? nxt_cmd.op : op_q;
        // Write enable stays up after any run so the core keeps seeing the zero word.
        we0_d     = (state_d != S_IDLE) || (state_q != S_IDLE) || we0_q;
        busy_d    = !(state_d == S_IDLE || state_d == S_FINISH);
        done_d    = (state_d == S_FINISH);
        blocked_d = host_wea && busy_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            wd_q       <= '0;
            cmd_q      <= '0;
            op_q       <= '0;
            we0_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_step_q <= '0;
            blocked_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            wd_q       <= wd_d;
            cmd_q      <= cmd_d;
            op_q       <= op_d;
            we0_q      <= we0_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_step_q <= err_step_d;
            blocked_q  <= blocked_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_step     = err_step_q;
    assign command_out  = cmd_q;
    assign command_we0  = we0_q;
    assign command_we1  = 1'b0;
    assign host_blocked = blocked_q;
    assign wea_ext      = host_wea & ~busy_q;

endmodule

// File: tb/tb_kem_dec_sequencer.sv
// tb_kem_dec_sequencer: directed scenarios against a behavioural core model with programmable
// done delay D and drop delay L; written command words are checked against a scoreboard queue.
module tb_kem_dec_sequencer;

    localparam logic [34:0] W0 = {10'd512, 10'd0,   10'd0,   5'd9};
    localparam logic [34:0] W1 = {10'd0,   10'd0,   10'd512, 5'd10};
    localparam logic [34:0] W2 = {10'd512, 10'd120, 10'd0,   5'd11};
    localparam logic [34:0] W3 = {10'd516, 10'd4,   10'd136, 5'd12};
    localparam logic [34:0] WZ = 35'd0;

    logic        clk, rst, start, abort, host_wea;
    logic        busy, done, error, command_we0, command_we1, wea_ext, host_blocked;
    logic [2:0]  err_step;
    logic [34:0] command_out;
    logic        done_vmul, done_bs2polvecp, done_unpack;

    int          checks, fails, done_cnt, blk_cnt;
    logic [34:0] exp_q[$];
    logic [34:0] last_cmd;

    // core model state
    int          D, L, cnt;
    logic [1:0]  ph;
    logic [4:0]  mop, never_op, stuck_op;
    logic        stuck_hi, raw, en;

    kem_dec_sequencer #(.NUM_STEPS(4), .TIMEOUT_CYCLES(100)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .err_step        (err_step),
        .command_out     (command_out),
        .command_we0     (command_we0),
        .command_we1     (command_we1),
        .done_shake      (1'b1),
        .done_vmul       (done_vmul),
        .done_addround   (1'b1),
        .done_addpack    (1'b1),
        .done_bs2polvecp (done_bs2polvecp),
        .done_unpack     (done_unpack),
        .host_wea        (host_wea),
        .wea_ext         (wea_ext),
        .host_blocked    (host_blocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Done rises D cycles after capture and falls L cycles after the zero word is written.
    assign raw = (ph == 2'd1 && cnt == 0) || ph == 2'd2 || (ph == 2'd3 && cnt != 0);
    assign en  = raw && (mop != never_op);
    assign done_bs2polvecp = en && mop == 5'd9;
    assign done_vmul       = en && mop == 5'd10;
    assign done_unpack     = (en && (mop == 5'd11 || mop == 5'd12)) || stuck_hi;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 2'd0; cnt <= 0; mop <= 5'd0; stuck_hi <= 1'b0;
        end else begin
            stuck_hi <= (stuck_op == 5'd0) ? 1'b0 : (stuck_hi || (ph == 2'd2 && mop == stuck_op));
            case (ph)
                2'd0: if (command_we0 && command_out != 35'd0) begin
                          ph <= 2'd1; cnt <= D - 1; mop <= command_out[4:0];
                      end
                2'd1: if (cnt != 0) cnt <= cnt - 1; else ph <= 2'd2;
                2'd2: if (command_we0 && command_out == 35'd0) begin
                          ph <= 2'd3; cnt <= L - 1;
                      end
                default: if (cnt != 0) cnt <= cnt - 1; else ph <= 2'd0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle; samples outputs on the falling edge and pops the scoreboard on every new command word.
    task automatic tick();
        logic [34:0] e;
        @(negedge clk);
        if (done) done_cnt++;
        if (host_blocked) blk_cnt++;
        if (command_out !== last_cmd) begin
            last_cmd = command_out;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            chk("cmd_word", {command_we0, command_out}, {1'b1, e});
        end
    endtask

    task automatic wait_cmd(input logic [34:0] w, input string tag);
        bit hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            tick();
            hit = (command_out === w);
        end
        chk(tag, hit, 1);
    endtask

    task automatic wait_model_idle();
        bit hit = (ph == 2'd0);
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            hit = (ph == 2'd0);
        end
        chk("model_idle_wait", hit, 1);
    endtask

    task automatic push_full();
        exp_q.push_back(W0); exp_q.push_back(WZ);
        exp_q.push_back(W1); exp_q.push_back(WZ);
        exp_q.push_back(W2); exp_q.push_back(WZ);
        exp_q.push_back(W3); exp_q.push_back(WZ);
    endtask

    task automatic run_full(input string tag);
        int  n = 0;
        bit  fin = 0;
        wait_model_idle();
        push_full();
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, 1);
        for (int i = 0; i < 400 && !fin; i++) begin
            tick();
            n++;
            fin = done;
        end
        chk({tag, "_cycles_to_done"}, n, 104);
        tick();
        tick();
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_we0_idle"}, command_we0, 1);
    endtask

    initial begin
        checks = 0; fails = 0; done_cnt = 0; blk_cnt = 0;
        last_cmd = '0;
        D = 20; L = 2; never_op = 5'd0; stuck_op = 5'd0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; host_wea = 1'b0;

        // reset state
        tick(); tick();
        chk("reset_outputs", {busy, done, error, err_step, command_out, command_we0, command_we1, host_blocked}, 0);
        rst = 1'b0;
        host_wea = 1'b1;
        tick();
        chk("idle_outputs", {busy, done, error, command_out, command_we0, host_blocked}, 0);
        chk("idle_wea_ext", wea_ext, 1);

        // nominal run with host writes held high throughout
        blk_cnt = 0;
        run_full("nominal");
        chk("nominal_blocked_cycles", blk_cnt, 104);
        chk("nominal_wea_after", wea_ext, 1);
        chk("nominal_we1", command_we1, 0);

        // start together with abort does not launch
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        tick(); tick(); tick();
        chk("start_abort_still_idle", {busy, command_out}, 0);

        // watchdog in WAIT_DONE of step 1
        never_op = 5'd10;
        wait_model_idle();
        exp_q.push_back(W0); exp_q.push_back(WZ); exp_q.push_back(W1); exp_q.push_back(WZ);
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_cmd(W1, "wd_reach_step1");
        for (int i = 0; i < 99; i++) tick();
        tick();
        chk("wd_before_limit", {error, busy, wea_ext}, 3'b010);
        tick();
        chk("wd_error", error, 1);
        chk("wd_err_step", err_step, 1);
        chk("wd_idle", {busy, command_out}, 0);
        chk("wd_wea_after", wea_ext, 1);
        chk("wd_no_done", done_cnt, 0);
        chk("wd_queue_empty", exp_q.size(), 0);
        never_op = 5'd0;

        // done_unpack stuck high: timeout in WAIT_LOW of step 2
        stuck_op = 5'd11;
        host_wea = 1'b0;
        wait_model_idle();
        exp_q.push_back(W0); exp_q.push_back(WZ); exp_q.push_back(W1); exp_q.push_back(WZ);
        exp_q.push_back(W2); exp_q.push_back(WZ);
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("stuck_error_cleared", error, 0);
        wait_cmd(W2, "stuck_reach_step2");
        begin
            bit hit = 0;
            for (int i = 0; i < 300 && !hit; i++) begin
                tick();
                hit = error;
            end
            chk("stuck_timeout_seen", hit, 1);
        end
        chk("stuck_err_step", err_step, 2);
        chk("stuck_idle", {busy, done_cnt[0]}, 0);
        chk("stuck_queue_empty", exp_q.size(), 0);
        stuck_op = 5'd0;
        tick();

        // abort in WAIT_DONE of step 2, then a clean restart
        wait_model_idle();
        exp_q.push_back(W0); exp_q.push_back(WZ); exp_q.push_back(W1); exp_q.push_back(WZ);
        exp_q.push_back(W2); exp_q.push_back(WZ);
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_run_error_cleared", error, 0);
        wait_cmd(W2, "abort_reach_step2");
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", {busy, command_out}, 0);
        chk("abort_error", error, 0);
        chk("abort_we0_held", command_we0, 1);
        tick(); tick(); tick();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_queue_empty", exp_q.size(), 0);
        run_full("restart");

        // asynchronous reset during CLEAR of step 1
        wait_model_idle();
        exp_q.push_back(W0); exp_q.push_back(WZ); exp_q.push_back(W1); exp_q.push_back(WZ);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_cmd(W1, "rst_reach_step1");
        wait_cmd(WZ, "rst_reach_clear");
        #2;
        rst = 1'b1;
        #1;
        chk("midrun_reset_outputs", {busy, done, error, err_step, command_out, command_we0, command_we1, host_blocked}, 0);
        tick();
        rst = 1'b0;
        chk("midrun_queue_empty", exp_q.size(), 0);
        run_full("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
